// File: rtl/hazard_control_unit_pkg.sv
// Shared pipeline definitions for the hazard controller: register address width,
// NOP encoding loaded by bubbles/flushes, and the controller state enum.
package hazard_control_unit_pkg;

  localparam int ADDR_W = 3;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2,
    FLUSH    = 2'd3
  } hcu_state_e;

endpackage

// File: rtl/hazard_control_unit_sat_counter.sv
// Saturating up-counter with enable and asynchronous clear; stops at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_o <= '0;
    end else if (en_i && (cnt_o != {CNT_W{1'b1}})) begin
      cnt_o <= cnt_o + ONE;
    end
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline stall/flush controller: load-use bubbles, multi-cycle memory freeze,
// and wrong-path flushing after taken branches. Outputs are Mealy.
module hazard_control_unit
  import hazard_control_unit_pkg::*;
#(
  parameter int BR_PENALTY  = 1,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [ADDR_W-1:0] id_rs_addr_i,
  input  logic [ADDR_W-1:0] id_rt_addr_i,
  input  logic              id_uses_rt_i,
  input  logic [ADDR_W-1:0] ex_write_addr_i,
  input  logic              ex_memread_i,
  input  logic              mem_req_i,
  input  logic              mem_ack_i,
  input  logic              branch_taken_i,
  output logic              pc_stall_o,
  output logic              ifid_stall_o,
  output logic              idex_stall_o,
  output logic              exmem_stall_o,
  output logic              idex_bubble_o,
  output logic              ifid_flush_o,
  output logic              mem_timeout_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam logic [2:0] BR_PEN    = 3'(BR_PENALTY);
  localparam logic [2:0] BR_PEN_M1 = 3'(BR_PENALTY - 1);
  localparam logic [7:0] TMO       = 8'(MEM_TIMEOUT);

  hcu_state_e state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic [2:0] flush_q, flush_d;
  logic       pend_br_q, pend_br_d;
  logic       bubble_owed_q, bubble_owed_d;
  logic       timeout_q, timeout_d;

  logic lu, mw;
  logic stall_all, lu_stall, bubble, flush;

  // Memory handshake: mem_req_i marks an access in MEM; the access is complete in
  // the cycle mem_ack_i is high. A request without ack freezes the whole pipeline.
  assign lu = ex_memread_i & ((ex_write_addr_i == id_rs_addr_i) |
                              (id_uses_rt_i & (ex_write_addr_i == id_rt_addr_i)));
  assign mw = mem_req_i & ~mem_ack_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= RUN;
      wait_q        <= '0;
      flush_q       <= '0;
      pend_br_q     <= 1'b0;
      bubble_owed_q <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      flush_q       <= flush_d;
      pend_br_q     <= pend_br_d;
      bubble_owed_q <= bubble_owed_d;
      timeout_q     <= timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    flush_d       = flush_q;
    pend_br_d     = pend_br_q;
    bubble_owed_d = bubble_owed_q;
    timeout_d     = timeout_q;
    stall_all     = 1'b0;
    lu_stall      = 1'b0;
    bubble        = 1'b0;
    flush         = 1'b0;
    unique case (state_q)
      RUN, LU_STALL: begin
        if (mw) begin
          stall_all = 1'b1;
          state_d   = MEM_WAIT;
          wait_d    = 8'd1;
          pend_br_d = branch_taken_i;
        end else if (branch_taken_i) begin
          // The ID instruction is wrong-path, so a coincident load-use is dropped.
          flush  = 1'b1;
          bubble = 1'b1;
          if (BR_PENALTY > 1) begin
            state_d       = FLUSH;
            flush_d       = BR_PEN_M1;
            bubble_owed_d = 1'b0;
          end else begin
            state_d = RUN;
          end
        end else if (lu && (state_q == RUN)) begin
          lu_stall = 1'b1;
          state_d  = LU_STALL;
        end else begin
          state_d = RUN;
        end
      end
      MEM_WAIT: begin
        if (mem_ack_i) begin
          pend_br_d = 1'b0;
          if (pend_br_q) begin
            state_d       = FLUSH;
            flush_d       = BR_PEN;
            bubble_owed_d = 1'b1;
          end else begin
            state_d = RUN;
          end
        end else if (wait_q == TMO) begin
          timeout_d = 1'b1;
          pend_br_d = 1'b0;
          state_d   = RUN;
        end else begin
          stall_all = 1'b1;
          wait_d    = wait_q + 8'd1;
        end
      end
      FLUSH: begin
        if (mw) begin
          stall_all = 1'b1;
          state_d   = MEM_WAIT;
          wait_d    = 8'd1;
          pend_br_d = 1'b1;
        end else begin
          flush         = 1'b1;
          bubble        = bubble_owed_q;
          bubble_owed_d = 1'b0;
          flush_d       = flush_q - 3'd1;
          if (flush_q <= 3'd1) state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Gated by reset so nothing leaks from live inputs while the pipeline is held.
  assign pc_stall_o    = rst_n_i & (stall_all | lu_stall);
  assign ifid_stall_o  = rst_n_i & (stall_all | lu_stall);
  assign idex_stall_o  = rst_n_i & stall_all;
  assign exmem_stall_o = rst_n_i & stall_all;
  assign idex_bubble_o = rst_n_i & (bubble | lu_stall);
  assign ifid_flush_o  = rst_n_i & flush;
  assign mem_timeout_o = timeout_q;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .en_i    (pc_stall_o),
    .cnt_o   (stall_cnt_o)
  );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: directed vectors with hand-computed expectations,
// plus a per-cycle reference model built from outstanding-work counters.
module tb_hazard_control_unit;

  localparam int BRP   = 3;
  localparam int TMO   = 5;
  localparam int CNT_W = 16;

  logic       clk, rst_n;
  logic [2:0] id_rs, id_rt, ex_write;
  logic       id_uses_rt, ex_memread, mem_req, mem_ack, branch_taken;
  logic       pc_stall, ifid_stall, idex_stall, exmem_stall, idex_bubble, ifid_flush;
  logic       mem_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [5:0] outs;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model state: work still owed by the pipeline controller.
  int          m_flush_left, m_waited;
  bit          m_in_mem, m_br_owed, m_bub_owed, m_lu_hold, m_tmo;
  int unsigned m_cnt;

  hazard_control_unit #(
    .BR_PENALTY  (BRP),
    .MEM_TIMEOUT (TMO),
    .CNT_W       (CNT_W)
  ) dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .id_rs_addr_i    (id_rs),
    .id_rt_addr_i    (id_rt),
    .id_uses_rt_i    (id_uses_rt),
    .ex_write_addr_i (ex_write),
    .ex_memread_i    (ex_memread),
    .mem_req_i       (mem_req),
    .mem_ack_i       (mem_ack),
    .branch_taken_i  (branch_taken),
    .pc_stall_o      (pc_stall),
    .ifid_stall_o    (ifid_stall),
    .idex_stall_o    (idex_stall),
    .exmem_stall_o   (exmem_stall),
    .idex_bubble_o   (idex_bubble),
    .ifid_flush_o    (ifid_flush),
    .mem_timeout_o   (mem_timeout),
    .stall_cnt_o     (stall_cnt)
  );

  // Order: pc, ifid, idex, exmem stalls, idex bubble, ifid flush.
  assign outs = {pc_stall, ifid_stall, idex_stall, exmem_stall, idex_bubble, ifid_flush};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin : compare
    logic [5:0] e;
    logic lu, mw, nh;
    if (!rst_n) begin
      m_flush_left = 0; m_waited = 0; m_in_mem = 0; m_br_owed = 0;
      m_bub_owed = 0; m_lu_hold = 0; m_tmo = 0; m_cnt = 0;
      chk("model_reset_outs", 32'(outs), 32'd0);
      chk("model_reset_cnt", 32'(stall_cnt), 32'd0);
    end else begin
      chk("model_stall_cnt", 32'(stall_cnt), m_cnt);
      chk("model_timeout", 32'(mem_timeout), 32'(m_tmo));
      lu = ex_memread && ((ex_write == id_rs) || (id_uses_rt && (ex_write == id_rt)));
      mw = mem_req && !mem_ack;
      e  = 6'b0;
      nh = 1'b0;
      if (m_in_mem) begin
        if (mem_ack) begin
          m_in_mem = 0;
          if (m_br_owed) begin m_flush_left = BRP; m_bub_owed = 1; end
          m_br_owed = 0;
        end else if (m_waited == TMO) begin
          m_tmo = 1; m_in_mem = 0; m_br_owed = 0;
        end else begin
          e = 6'b111100;
          m_waited++;
        end
      end else if (mw) begin
        e = 6'b111100;
        m_br_owed = (m_flush_left > 0) ? 1'b1 : branch_taken;
        m_in_mem = 1;
        m_waited = 1;
      end else if (m_flush_left > 0) begin
        e = {4'b0000, m_bub_owed, 1'b1};
        m_bub_owed = 0;
        m_flush_left--;
      end else if (branch_taken) begin
        e = 6'b000011;
        m_flush_left = BRP - 1;
      end else if (lu && !m_lu_hold) begin
        e = 6'b110010;
        nh = 1'b1;
      end
      m_lu_hold = nh;
      chk("model_outs", 32'(outs), 32'(e));
      chk("ifid_stall_vs_flush", 32'(ifid_stall & ifid_flush), 32'd0);
      if (e[5] && (m_cnt != (32'd1 << CNT_W) - 1)) m_cnt++;
    end
  end

  task automatic drive(input logic mr, input logic [2:0] wa, input logic [2:0] rs,
                       input logic [2:0] rt, input logic urt, input logic req,
                       input logic ack, input logic br);
    ex_memread = mr; ex_write = wa; id_rs = rs; id_rt = rt; id_uses_rt = urt;
    mem_req = req; mem_ack = ack; branch_taken = br;
    #1;
  endtask

  task automatic idle;
    drive(1'b0, 3'd0, 3'd1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic release_reset;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    idle();
    tick();
  endtask

  task automatic reset_dut;
    rst_n = 1'b0;
    drive(1'b1, 3'd3, 3'd3, 3'd3, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("reset_outs", 32'(outs), 32'd0);
    chk("reset_cnt", 32'(stall_cnt), 32'd0);
    chk("reset_timeout", 32'(mem_timeout), 32'd0);
    release_reset();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    @(posedge clk);
    #1;

    // 1: load-use on rs, one bubble, no re-detection in the next cycle
    reset_dut();
    drive(1'b1, 3'd3, 3'd3, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t1_lu", 32'(outs), 32'b110010);
    tick();
    drive(1'b1, 3'd3, 3'd3, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t1_clean", 32'(outs), 32'd0);
    tick();
    idle();
    chk("t1_cnt", 32'(stall_cnt), 32'd1);
    tick();

    // 2: rt match ignored unless the instruction reads rt
    reset_dut();
    drive(1'b1, 3'd3, 3'd1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t2_no_rt", 32'(outs), 32'd0);
    tick();
    drive(1'b1, 3'd3, 3'd1, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t2_rt", 32'(outs), 32'b110010);
    tick();
    idle();
    chk("t2_cnt", 32'(stall_cnt), 32'd1);
    tick();

    // 3: memory freeze, ack on the fifth cycle
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 3'd0, 3'd1, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("t3_freeze", 32'(outs), 32'b111100);
      tick();
    end
    drive(1'b0, 3'd0, 3'd1, 3'd2, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("t3_ack", 32'(outs), 32'd0);
    tick();
    idle();
    chk("t3_cnt", 32'(stall_cnt), 32'd4);
    chk("t3_no_timeout", 32'(mem_timeout), 32'd0);
    tick();

    // 4: taken branch with a coincident load-use
    reset_dut();
    drive(1'b1, 3'd3, 3'd3, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t4_br_first", 32'(outs), 32'b000011);
    tick();
    for (int i = 0; i < 2; i++) begin
      idle();
      chk("t4_br_flush", 32'(outs), 32'b000001);
      tick();
    end
    idle();
    chk("t4_br_done", 32'(outs), 32'd0);
    chk("t4_cnt", 32'(stall_cnt), 32'd0);
    tick();

    // 5: branch held while memory is frozen; flush follows the ack
    reset_dut();
    drive(1'b0, 3'd0, 3'd1, 3'd2, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("t5_enter", 32'(outs), 32'b111100);
    tick();
    drive(1'b0, 3'd0, 3'd1, 3'd2, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("t5_wait", 32'(outs), 32'b111100);
    tick();
    drive(1'b0, 3'd0, 3'd1, 3'd2, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("t5_ack", 32'(outs), 32'd0);
    tick();
    idle();
    chk("t5_flush_first", 32'(outs), 32'b000011);
    tick();
    for (int i = 0; i < 2; i++) begin
      idle();
      chk("t5_flush", 32'(outs), 32'b000001);
      tick();
    end
    idle();
    chk("t5_done", 32'(outs), 32'd0);
    chk("t5_cnt", 32'(stall_cnt), 32'd2);
    tick();

    // 6: memory timeout is sticky; asynchronous reset mid-flush
    reset_dut();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 3'd0, 3'd1, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("t6_freeze", 32'(outs), 32'b111100);
      tick();
    end
    drive(1'b0, 3'd0, 3'd1, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t6_abort", 32'(outs), 32'd0);
    chk("t6_pre_timeout", 32'(mem_timeout), 32'd0);
    tick();
    idle();
    chk("t6_timeout", 32'(mem_timeout), 32'd1);
    chk("t6_cnt", 32'(stall_cnt), 32'd5);
    tick();
    idle();
    chk("t6_sticky", 32'(mem_timeout), 32'd1);
    tick();
    drive(1'b0, 3'd0, 3'd1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t6_br", 32'(outs), 32'b000011);
    tick();
    idle();
    chk("t6_mid_flush", 32'(outs), 32'b000001);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_async_outs", 32'(outs), 32'd0);
    chk("t6_async_timeout", 32'(mem_timeout), 32'd0);
    chk("t6_async_cnt", 32'(stall_cnt), 32'd0);
    release_reset();
    idle();
    chk("t6_after_reset", 32'(outs), 32'd0);
    tick();

    // Mixed vectors checked by the model only
    drive(1'b1, 3'd5, 3'd0, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 3'd5, 3'd0, 3'd5, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    idle(); tick();
    idle(); tick();
    drive(1'b0, 3'd0, 3'd1, 3'd2, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 3'd0, 3'd0, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 3'd0, 3'd0, 3'd7, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b0, 3'd0, 3'd1, 3'd2, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    idle(); tick();
    idle(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
